// File: rtl/motor_pkg.sv
// Shared encodings for the motor scheduler: FSM states, travel direction
// and requester identity.
package motor_pkg;

  typedef enum logic [2:0] {
    SM_SCHED_IDLE   = 3'd0,
    SM_SCHED_DEAD   = 3'd1,
    SM_SCHED_RUN_UP = 3'd2,
    SM_SCHED_RUN_DN = 3'd3,
    SM_SCHED_FAULT  = 3'd4
  } sched_state_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam logic OWN_LOCAL  = 1'b0;
  localparam logic OWN_REMOTE = 1'b1;

endpackage

// File: rtl/motor_sched_if.sv
// Arbitration link between the scheduler and its round-robin picker.
// Level semantics, no handshake: candidates and last_grant are valid every
// cycle, and the one-hot pick answers them combinationally in the same cycle.
interface motor_sched_if;
  logic cand_local;
  logic cand_remote;
  logic last_grant;
  logic pick_local;
  logic pick_remote;

  modport master (
    output cand_local, cand_remote, last_grant,
    input  pick_local, pick_remote
  );

  modport slave (
    input  cand_local, cand_remote, last_grant,
    output pick_local, pick_remote
  );
endinterface

// File: rtl/motor_rr_arb2.sv
// Two-requester round-robin picker: a lone candidate wins, a tie goes to the
// requester that was not granted last. Purely combinational.
module motor_rr_arb2
  import motor_pkg::*;
(
  motor_sched_if.slave arb
);

  always_comb begin
    arb.pick_local  = 1'b0;
    arb.pick_remote = 1'b0;
    if (arb.cand_local && arb.cand_remote) begin
      arb.pick_local  = (arb.last_grant == OWN_REMOTE);
      arb.pick_remote = (arb.last_grant == OWN_LOCAL);
    end else begin
      arb.pick_local  = arb.cand_local;
      arb.pick_remote = arb.cand_remote;
    end
  end

endmodule

// File: rtl/motor_sched.sv
// Motor scheduler: arbitrates local/remote run requests onto one up/down
// drive with dead time, abort, run timeout and a latched fault state.
module motor_sched #(
  parameter int DEAD_CYC    = 8,
  parameter int DEAD_W      = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int TIMEOUT_W   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_local,
  input  logic       dir_local,
  input  logic       req_remote,
  input  logic       dir_remote,
  input  logic       stop,
  input  logic       up_limit,
  input  logic       dn_limit,
  input  logic       fault_clr,
  output logic       motor_up_q,
  output logic       motor_dn_q,
  output logic       grant_local,
  output logic       grant_remote,
  output logic       fault,
  output logic [2:0] sched_state
);
  import motor_pkg::*;

  localparam logic [DEAD_W-1:0]    DEAD_INIT = DEAD_W'(DEAD_CYC - 1);
  localparam logic [TIMEOUT_W-1:0] RUN_LAST  = TIMEOUT_W'(TIMEOUT_CYC - 1);

  sched_state_e          state_q, state_d;
  logic [DEAD_W-1:0]     dead_q, dead_d;
  logic [TIMEOUT_W-1:0]  run_q, run_d;
  logic                  last_q, last_d;
  logic                  owner_q, owner_d;
  logic                  dir_q, dir_d;
  logic                  motor_up_d, motor_dn_d;
  logic                  grant_local_q, grant_local_d;
  logic                  grant_remote_q, grant_remote_d;
  logic                  fault_q, fault_d;

  logic sensor_fault;
  logic owner_req;
  logic travel_limit;

  motor_sched_if u_arb_if ();

  assign sensor_fault = up_limit && dn_limit;
  assign owner_req    = (owner_q == OWN_REMOTE) ? req_remote : req_local;
  assign travel_limit = (dir_q == DIR_DN) ? dn_limit : up_limit;

  // A request is only a candidate if its own travel limit is clear.
  assign u_arb_if.cand_local  = !stop && req_local &&
                                !((dir_local == DIR_UP) ? up_limit : dn_limit);
  assign u_arb_if.cand_remote = !stop && req_remote &&
                                !((dir_remote == DIR_UP) ? up_limit : dn_limit);
  assign u_arb_if.last_grant  = last_q;

  motor_rr_arb2 u_arb (
    .arb (u_arb_if)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= SM_SCHED_IDLE;
      dead_q         <= '0;
      run_q          <= '0;
      last_q         <= OWN_REMOTE;
      owner_q        <= OWN_LOCAL;
      dir_q          <= DIR_DN;
      motor_up_q     <= 1'b0;
      motor_dn_q     <= 1'b0;
      grant_local_q  <= 1'b0;
      grant_remote_q <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      dead_q         <= dead_d;
      run_q          <= run_d;
      last_q         <= last_d;
      owner_q        <= owner_d;
      dir_q          <= dir_d;
      motor_up_q     <= motor_up_d;
      motor_dn_q     <= motor_dn_d;
      grant_local_q  <= grant_local_d;
      grant_remote_q <= grant_remote_d;
      fault_q        <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dead_d  = dead_q;
    run_d   = run_q;
    last_d  = last_q;
    owner_d = owner_q;
    dir_d   = dir_q;
    if (sensor_fault) begin
      state_d = SM_SCHED_FAULT;
    end else begin
      case (state_q)
        SM_SCHED_IDLE: begin
          if (u_arb_if.pick_local || u_arb_if.pick_remote) begin
            state_d = SM_SCHED_DEAD;
            dead_d  = DEAD_INIT;
            owner_d = u_arb_if.pick_remote ? OWN_REMOTE : OWN_LOCAL;
            last_d  = u_arb_if.pick_remote ? OWN_REMOTE : OWN_LOCAL;
            dir_d   = u_arb_if.pick_remote ? dir_remote : dir_local;
          end
        end
        SM_SCHED_DEAD: begin
          if (stop || !owner_req) begin
            state_d = SM_SCHED_IDLE;
          end else if (dead_q == '0) begin
            state_d = (dir_q == DIR_UP) ? SM_SCHED_RUN_UP : SM_SCHED_RUN_DN;
            run_d   = '0;
          end else begin
            dead_d = dead_q - DEAD_W'(1);
          end
        end
        SM_SCHED_RUN_UP, SM_SCHED_RUN_DN: begin
          if (travel_limit || stop || !owner_req) begin
            state_d = SM_SCHED_IDLE;
          end else if (run_q == RUN_LAST) begin
            state_d = SM_SCHED_FAULT;
          end else begin
            run_d = run_q + TIMEOUT_W'(1);
          end
        end
        SM_SCHED_FAULT: begin
          if (fault_clr) begin
            state_d = SM_SCHED_IDLE;
          end
        end
        default: state_d = SM_SCHED_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register with it.
  always_comb begin
    motor_up_d     = (state_d == SM_SCHED_RUN_UP);
    motor_dn_d     = (state_d == SM_SCHED_RUN_DN);
    grant_local_d  = 1'b0;
    grant_remote_d = 1'b0;
    if (state_d == SM_SCHED_DEAD || state_d == SM_SCHED_RUN_UP ||
        state_d == SM_SCHED_RUN_DN) begin
      grant_local_d  = (owner_d == OWN_LOCAL);
      grant_remote_d = (owner_d == OWN_REMOTE);
    end
    fault_d = (state_d == SM_SCHED_FAULT);
  end

  assign grant_local  = grant_local_q;
  assign grant_remote = grant_remote_q;
  assign fault        = fault_q;
  assign sched_state  = state_q;

endmodule

// File: tb/tb_motor_sched.sv
// Bench for motor_sched: directed scenarios then random traffic, all checked
// each cycle against a behavioural model of the scheduling rules.
`timescale 1ns/1ps
module tb_motor_sched;

  localparam int DEAD_CYC    = 8;
  localparam int DEAD_W      = 4;
  localparam int TIMEOUT_CYC = 20;
  localparam int TIMEOUT_W   = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic req_local = 0, dir_local = 0, req_remote = 0, dir_remote = 0;
  logic stop = 0, up_limit = 0, dn_limit = 0, fault_clr = 0;
  logic motor_up_q, motor_dn_q, grant_local, grant_remote, fault;
  logic [2:0] sched_state;

  motor_sched #(
    .DEAD_CYC(DEAD_CYC), .DEAD_W(DEAD_W),
    .TIMEOUT_CYC(TIMEOUT_CYC), .TIMEOUT_W(TIMEOUT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_local(req_local), .dir_local(dir_local),
    .req_remote(req_remote), .dir_remote(dir_remote),
    .stop(stop), .up_limit(up_limit), .dn_limit(dn_limit),
    .fault_clr(fault_clr),
    .motor_up_q(motor_up_q), .motor_dn_q(motor_dn_q),
    .grant_local(grant_local), .grant_remote(grant_remote),
    .fault(fault), .sched_state(sched_state)
  );

  // Standalone picker instance, exercised directly.
  motor_sched_if tb_arb_if ();
  motor_rr_arb2 u_arb_chk (.arb(tb_arb_if));

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 dead time, 2 running, 3 faulted
  int m_mode, m_owner, m_last, m_dir, m_left, m_ran;

  task automatic model_reset();
    m_mode = 0; m_owner = 0; m_last = 1; m_dir = 0; m_left = 0; m_ran = 0;
  endtask

  function automatic bit blocked(input logic d);
    return d ? up_limit : dn_limit;
  endfunction

  task automatic model_edge();
    bit cl, cr, oreq;
    int who;
    oreq = (m_owner == 1) ? req_remote : req_local;
    if (up_limit && dn_limit) begin
      m_mode = 3;
    end else if (m_mode == 0) begin
      cl = req_local && !stop && !blocked(dir_local);
      cr = req_remote && !stop && !blocked(dir_remote);
      if (cl || cr) begin
        if (cl && cr) who = (m_last == 1) ? 0 : 1;
        else          who = cl ? 0 : 1;
        m_owner = who;
        m_last  = who;
        m_dir   = (who == 1) ? int'(dir_remote) : int'(dir_local);
        m_left  = DEAD_CYC;
        m_mode  = 1;
      end
    end else if (m_mode == 1) begin
      if (stop || !oreq) m_mode = 0;
      else begin
        m_left--;
        if (m_left == 0) begin
          m_mode = 2;
          m_ran  = 0;
        end
      end
    end else if (m_mode == 2) begin
      if (stop || !oreq || ((m_dir == 1) ? up_limit : dn_limit)) m_mode = 0;
      else begin
        m_ran++;
        if (m_ran == TIMEOUT_CYC) m_mode = 3;
      end
    end else begin
      if (fault_clr) m_mode = 0;
    end
  endtask

  task automatic check_outputs();
    logic [7:0] e_state;
    bit act;
    act = (m_mode == 1) || (m_mode == 2);
    case (m_mode)
      0: e_state = 8'd0;
      1: e_state = 8'd1;
      2: e_state = (m_dir == 1) ? 8'd2 : 8'd3;
      default: e_state = 8'd4;
    endcase
    chk("state",        {5'b0, sched_state}, e_state);
    chk("motor_up",     {7'b0, motor_up_q},   {7'b0, (m_mode == 2) && (m_dir == 1)});
    chk("motor_dn",     {7'b0, motor_dn_q},   {7'b0, (m_mode == 2) && (m_dir == 0)});
    chk("grant_local",  {7'b0, grant_local},  {7'b0, act && (m_owner == 0)});
    chk("grant_remote", {7'b0, grant_remote}, {7'b0, act && (m_owner == 1)});
    chk("fault",        {7'b0, fault},        {7'b0, m_mode == 3});
    chk("excl_drive",   {7'b0, motor_up_q & motor_dn_q},     8'd0);
    chk("excl_grant",   {7'b0, grant_local & grant_remote}, 8'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_local = 0; dir_local = 0; req_remote = 0; dir_remote = 0;
    stop = 0; up_limit = 0; dn_limit = 0; fault_clr = 0;
    model_reset();
    #12;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic wait_grant(input string tag);
    int budget;
    budget = 6;
    tick();
    while (!(grant_local || grant_remote) && budget > 0) begin
      tick();
      budget--;
    end
    chk({tag, "_grant_seen"}, {7'b0, grant_local | grant_remote}, 8'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    chk("reset_state", {5'b0, sched_state}, 8'd0);
    chk("reset_drv",   {6'b0, motor_up_q, motor_dn_q}, 8'd0);
    chk("reset_out",   {5'b0, grant_local, grant_remote, fault}, 8'd0);

    // 1: single local up request, dead time, stop at limit
    req_local = 1; dir_local = 1;
    tick();
    chk("t1_grant_e1", {7'b0, grant_local}, 8'd1);
    ticks(DEAD_CYC - 1);
    chk("t1_up_e8", {7'b0, motor_up_q}, 8'd0);
    tick();
    chk("t1_up_e9", {7'b0, motor_up_q}, 8'd1);
    ticks(3);
    up_limit = 1;
    tick();
    chk("t1_limit_stop", {5'b0, sched_state}, 8'd0);
    chk("t1_limit_drv",  {6'b0, motor_up_q, grant_local}, 8'd0);
    req_local = 0; up_limit = 0;
    tick();

    // 2: contested requests alternate local, remote, local
    do_reset();
    exp_q.push_back(8'd0); exp_q.push_back(8'd1); exp_q.push_back(8'd0);
    for (int r = 0; r < 3; r++) begin
      req_local = 1; req_remote = 1; dir_local = 1; dir_remote = 0;
      wait_grant("t2");
      chk("t2_owner", {7'b0, grant_remote}, exp_q.pop_front());
      ticks(DEAD_CYC + 3);
      req_local = 0; req_remote = 0;
      ticks(2);
    end

    // 3: request toward an active limit is ignored until the limit clears
    req_remote = 1; dir_remote = 0; dn_limit = 1;
    ticks(4);
    chk("t3_blocked", {5'b0, grant_remote, motor_up_q, motor_dn_q}, 8'd0);
    dn_limit = 0;
    tick();
    chk("t3_released", {7'b0, grant_remote}, 8'd1);
    req_remote = 0;
    ticks(2);

    // 4: run timeout, then clear with the request still held
    req_remote = 1; dir_remote = 0;
    wait_grant("t4");
    ticks(DEAD_CYC);
    chk("t4_run_dn", {7'b0, motor_dn_q}, 8'd1);
    ticks(TIMEOUT_CYC - 1);
    chk("t4_still_run", {7'b0, motor_dn_q}, 8'd1);
    tick();
    chk("t4_fault", {7'b0, fault}, 8'd1);
    chk("t4_fault_st", {5'b0, sched_state}, 8'd4);
    chk("t4_fault_drv", {7'b0, motor_dn_q}, 8'd0);
    fault_clr = 1;
    tick();
    chk("t4_cleared", {7'b0, fault}, 8'd0);
    fault_clr = 0;
    tick();
    chk("t4_rearb", {7'b0, grant_remote}, 8'd1);
    req_remote = 0;
    ticks(2);

    // 5: aborts during dead time and during run
    req_local = 1; dir_local = 0;
    wait_grant("t5");
    ticks(3);
    req_local = 0;
    tick();
    chk("t5_dead_abort", {5'b0, sched_state}, 8'd0);
    ticks(DEAD_CYC);
    chk("t5_no_pulse", {6'b0, motor_up_q, motor_dn_q}, 8'd0);
    req_local = 1;
    wait_grant("t5b");
    ticks(DEAD_CYC + 3);
    req_local = 0;
    tick();
    chk("t5_run_abort", {7'b0, motor_dn_q}, 8'd0);
    tick();

    // 6: both limits while running, clear blocked until one releases
    req_local = 1; dir_local = 1;
    wait_grant("t6");
    ticks(DEAD_CYC + 2);
    up_limit = 1; dn_limit = 1;
    tick();
    chk("t6_sensor", {5'b0, sched_state}, 8'd4);
    fault_clr = 1;
    ticks(2);
    chk("t6_hold", {5'b0, sched_state}, 8'd4);
    dn_limit = 0;
    tick();
    chk("t6_clear", {5'b0, sched_state}, 8'd0);
    fault_clr = 0; up_limit = 0; req_local = 0;
    tick();

    // 7: asynchronous reset mid-run drops drives immediately
    req_local = 1; dir_local = 1;
    wait_grant("t7");
    ticks(DEAD_CYC + 1);
    rst_n = 1'b0;
    #1;
    chk("t7_async_drv", {6'b0, motor_up_q, grant_local}, 8'd0);
    chk("t7_async_st",  {5'b0, sched_state}, 8'd0);
    model_reset();
    req_local = 0;
    #10;
    rst_n = 1'b1;

    // picker standalone truth table
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic [7:0] e;
      v = 3'(i);
      tb_arb_if.cand_local  = v[0];
      tb_arb_if.cand_remote = v[1];
      tb_arb_if.last_grant  = v[2];
      #1;
      if (v[0] && v[1]) e = v[2] ? 8'd1 : 8'd2;
      else              e = {6'b0, v[1], v[0]};
      chk("arb_pick", {6'b0, tb_arb_if.pick_remote, tb_arb_if.pick_local}, e);
    end

    // random traffic
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) < 8)  req_local  = ~req_local;
      if ($urandom_range(0, 99) < 8)  req_remote = ~req_remote;
      if ($urandom_range(0, 99) < 10) dir_local  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 10) dir_remote = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 4)  up_limit   = ~up_limit;
      if ($urandom_range(0, 99) < 4)  dn_limit   = ~dn_limit;
      stop      = ($urandom_range(0, 99) < 3);
      fault_clr = ($urandom_range(0, 99) < 20);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
